// File: rtl/dmem_responder.sv
// dmem_responder: single-port data-memory responder for a core's load/store
// unit. Accepts one request at a time, waits WAIT_CYCLES, then answers with a
// one-cycle response pulse. Stores are committed on the edge entering RESP.
// Optional build macro: DMEM_MISALIGN_TRAP_EN turns misaligned half/word
// accesses into errors instead of silently aligning the address.
module dmem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int MEM_BYTES   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [9:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

  state_t      state, state_next;
  logic [3:0]  wait_cnt;

  logic        lat_write;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [9:0]  lat_addr;
  logic [31:0] lat_wdata;

  logic        src_write;
  logic [1:0]  src_size;
  logic        src_unsigned;
  logic [9:0]  src_addr;
  logic [31:0] src_wdata;
  logic        src_err;
  logic [9:0]  eff_addr;
  logic [3:0]  byte_en;
  logic [9:0]  lane_addr [4];
  logic [7:0]  rd_byte [4];
  logic        accept;
  logic        commit;

  logic [7:0]  mem [MEM_BYTES];

  // Force the low address bits to the natural alignment of the access size.
  function automatic logic [9:0] align_addr(input logic [1:0] size, input logic [9:0] addr);
    case (size)
      2'b01:   return {addr[9:1], 1'b0};
      2'b10:   return {addr[9:2], 2'b00};
      default: return addr;
    endcase
  endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
  // A half on an odd byte or a word off a 4-byte boundary is misaligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] low);
    return ((size == 2'b01) && low[0]) || ((size == 2'b10) && (low != 2'b00));
  endfunction
`endif

  // Pick the request fields: live inputs while IDLE (so a zero-wait store can
  // commit on its accept edge), the latched copy once the request is in flight.
  always_comb begin
    src_write    = lat_write;
    src_size     = lat_size;
    src_unsigned = lat_unsigned;
    src_addr     = lat_addr;
    src_wdata    = lat_wdata;
    if (state == IDLE) begin
      src_write    = req_write;
      src_size     = req_size;
      src_unsigned = req_unsigned;
      src_addr     = req_addr;
      src_wdata    = req_wdata;
    end
    src_err = (src_size == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (misaligned(src_size, src_addr[1:0])) src_err = 1'b1;
`endif
    eff_addr = align_addr(src_size, src_addr);
    case (src_size)
      2'b00:   byte_en = 4'b0001;
      2'b01:   byte_en = 4'b0011;
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
    for (int k = 0; k < 4; k++) begin
      lane_addr[k] = eff_addr + 10'(k);
      rd_byte[k]   = mem[lane_addr[k]];
    end
  end

  // Next-state logic and all handshake/response outputs.
  always_comb begin
    state_next = state;
    req_ready  = (state == IDLE);
    busy       = (state != IDLE);
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
        resp_valid = 1'b1;
        resp_err   = src_err;
        if (!src_write && !src_err) begin
          case (src_size)
            2'b00:   resp_rdata = src_unsigned ? {24'h0, rd_byte[0]}
                                               : {{24{rd_byte[0][7]}}, rd_byte[0]};
            2'b01:   resp_rdata = src_unsigned ? {16'h0, rd_byte[1], rd_byte[0]}
                                               : {{16{rd_byte[1][7]}}, rd_byte[1], rd_byte[0]};
            default: resp_rdata = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
          endcase
        end
      end
      default: state_next = IDLE;
    endcase
    commit = !reset && src_write && !src_err && (state != RESP) && (state_next == RESP);
  end

  // State register, wait-state down-counter and request capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state <= state_next;
      if (accept) begin
        wait_cnt     <= CNT_INIT;
        lat_write    <= req_write;
        lat_size     <= req_size;
        lat_unsigned <= req_unsigned;
        lat_addr     <= req_addr;
        lat_wdata    <= req_wdata;
      end else if (state == WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  // Storage array write; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (commit && byte_en[k]) mem[lane_addr[k]] <= src_wdata[8*k +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder. A driver issues
// directed and random requests and pushes predictions from a byte-array
// reference model; a monitor checks every response pulse and idle cycle.
module tb_dmem_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  logic [7:0] ref_mem [1024];

  dmem_responder #(.WAIT_CYCLES(W), .MEM_BYTES(1024)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  // Free-running clock and edge counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, act, want);
    end
  endtask

  // Reference model: memory as a byte array, responses from plain arithmetic.
  task automatic predict(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [9:0] addr, input logic [31:0] wdata,
                         output logic err, output logic [31:0] rdata);
    int n;
    int base;
    logic [31:0] v;
    err = (size == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (size == 2'b01 && (addr % 2) != 0) err = 1'b1;
    if (size == 2'b10 && (addr % 4) != 0) err = 1'b1;
`endif
    rdata = 32'h0;
    if (!err) begin
      n    = 1 << size;
      base = int'(addr) - (int'(addr) % n);
      if (wr) begin
        for (int i = 0; i < n; i++) ref_mem[base + i] = 8'(wdata >> (8 * i));
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
        if (!uns && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        rdata = v;
      end
    end
  endtask

  // Present one request, wait (bounded) for acceptance, then record the prediction.
  task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic uns,
                               input logic [9:0] addr, input logic [31:0] wdata);
    int   waited = 0;
    exp_t e;
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    while (!req_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got ready=%0b want 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    predict(wr, size, uns, addr, wdata, e.err, e.rdata);
    e.cyc = cyc + 1 + W;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if ($urandom_range(0, 1) == 0) req_valid = 1'b0;
    @(negedge clk);
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    checkOutput("ready_after_accept", 32'(req_ready), 32'd0);
  endtask

  task automatic drain();
    int waited = 0;
    @(negedge clk);
    req_valid = 1'b0;
    while (sb.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: got pending=%0d want 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every response pulse pops one prediction; idle cycles must be quiet.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (resp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_resp: got resp_valid=1 want 0 (rdata 0x%08h)", resp_rdata);
        end else begin
          e = sb.pop_front();
          checkOutput("resp_rdata", resp_rdata, e.rdata);
          checkOutput("resp_err", 32'(resp_err), 32'(e.err));
          checkOutput("resp_latency_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        checkOutput("idle_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("idle_rdata", resp_rdata, 32'h0);
        checkOutput("idle_err", 32'(resp_err), 32'd0);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, fill memory, directed cases, abort case, random traffic.
  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 10'h0;
    req_wdata    = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset_rdata", resp_rdata, 32'h0);
    checkOutput("reset_err", 32'(resp_err), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    for (int a = 0; a < 1024; a += 4) applyStimulus(1'b1, 2'b10, 1'b0, 10'(a), $urandom);
    drain();

    applyStimulus(1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 10'h010, 32'h0);
    applyStimulus(1'b0, 2'b00, 1'b0, 10'h013, 32'h0);
    applyStimulus(1'b0, 2'b00, 1'b1, 10'h013, 32'h0);
    applyStimulus(1'b0, 2'b01, 1'b0, 10'h010, 32'h0);
    applyStimulus(1'b1, 2'b00, 1'b0, 10'h011, 32'h0000005A);
    applyStimulus(1'b0, 2'b10, 1'b1, 10'h010, 32'h0);
    applyStimulus(1'b0, 2'b01, 1'b1, 10'h3FF, 32'h0);
    applyStimulus(1'b0, 2'b11, 1'b0, 10'h010, 32'h0);
    applyStimulus(1'b1, 2'b11, 1'b0, 10'h010, 32'hFFFFFFFF);
    applyStimulus(1'b0, 2'b10, 1'b0, 10'h010, 32'h0);
    applyStimulus(1'b1, 2'b10, 1'b0, 10'h020, 32'hA5A5A5A5);
    drain();

    // Store accepted, then reset one cycle later: no commit and no response.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'b10;
    req_addr  = 10'h020;
    req_wdata = 32'h12345678;
    checkOutput("abort_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_ready_after_reset", 32'(req_ready), 32'd1);
    checkOutput("abort_busy_after_reset", 32'(busy), 32'd0);
    repeat (W + 3) @(negedge clk);
    applyStimulus(1'b0, 2'b10, 1'b0, 10'h020, 32'h0);
    drain();

    for (int i = 0; i < 300; i++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      applyStimulus(1'($urandom), sz, 1'($urandom), 10'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, is the number of wait-state cycles between request accept and response, legal range 0..15.
REQ-002 Parameter MEM_BYTES, default 1024, is the byte capacity of the storage array, addressed by req_addr[9:0].
REQ-003 clk  input  1  is the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  is a synchronous, active-high reset.
REQ-005 req_valid  input  1  means the core presents a load/store request.
REQ-006 req_ready  output  1  means the responder accepts a request this cycle.
REQ-007 req_write  input  1  selects store (1) or load (0).
REQ-008 req_size  input  2  selects access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 req_unsigned  input  1  selects load extension: 0 sign-extend, 1 zero-extend.
REQ-010 req_addr  input  10  is the byte address, little-endian.
REQ-011 req_wdata  input  32  is store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 resp_valid  output  1  is a one-cycle pulse marking request completion.
REQ-013 resp_rdata  output  32  carries extended load data, valid only with resp_valid.
REQ-014 resp_err  output  1  flags an erroneous request, valid only with resp_valid.
REQ-015 busy  output  1  is high whenever the FSM is not IDLE.

Function
REQ-016 FSM states are IDLE, WAIT and RESP; req_ready SHALL equal (state==IDLE).
REQ-017 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; all req_* fields SHALL be latched at that edge.
REQ-018 After accept, IDLE->WAIT if WAIT_CYCLES>0, else IDLE->RESP; WAIT SHALL hold for exactly WAIT_CYCLES cycles via a down-counter, then go to RESP.
REQ-019 In RESP, resp_valid SHALL be 1 for exactly one cycle and the next state SHALL be IDLE; back-to-back requests therefore have a one-cycle IDLE gap.
REQ-020 Latency: resp_valid SHALL assert WAIT_CYCLES+1 cycles after the accept edge.
REQ-021 Store bytes SHALL be committed to the array on the edge that enters RESP; a load issued in the next accepted request SHALL return the new data.
REQ-022 Loads SHALL read bytes little-endian and extend per req_size/req_unsigned; a word load ignores req_unsigned.
REQ-023 Stores SHALL write only the 1, 2 or 4 addressed bytes; other bytes SHALL remain unchanged.
REQ-024 req_size=11 SHALL produce resp_err=1, resp_rdata=0 and no array write.
REQ-025 resp_rdata SHALL be 0 for stores and when resp_valid=0; resp_err SHALL be 0 when resp_valid=0.
REQ-026 req_valid while not IDLE SHALL be ignored without side effects.
REQ-027 Array contents SHALL NOT be reset; they are undefined until written.

Reset
REQ-028 With reset=1 on an edge, state SHALL go to IDLE, the wait counter SHALL clear to 0, and resp_valid, resp_err and busy SHALL be 0, resp_rdata 0, and req_ready 1 after the edge.
REQ-029 Reset mid-operation SHALL abort the pending request: no store commit and no response.

Configuration
REQ-030 With macro DMEM_MISALIGN_TRAP_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL complete with resp_err=1, resp_rdata=0 and no write.
REQ-031 Without DMEM_MISALIGN_TRAP_EN, the low address bits SHALL be forced to alignment (half: addr[0]=0; word: addr[1:0]=0) and the access SHALL complete normally with resp_err=0.

Verification
REQ-032 Reset, then store word 0xDEADBEEF at 0x010, then load word at 0x010 (WAIT_CYCLES=2) -> resp_rdata=0xDEADBEEF with resp_valid 3 cycles after each accept.
REQ-033 After REQ-032, load byte at 0x013 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; load half signed at 0x010 -> 0xFFFFBEEF.
REQ-034 Store byte 0x5A at 0x011 over 0xDEADBEEF, then load word at 0x010 -> 0xDEAD5AEF.
REQ-035 Half load at 0x3FF: with DMEM_MISALIGN_TRAP_EN -> resp_err=1, rdata 0; without -> data from 0x3FE, resp_err=0; req_size=11 -> resp_err=1 in both builds.
REQ-036 Assert reset one cycle after accepting a store of 0x12345678 to 0x020, then load 0x020 -> old contents returned, no resp_valid for the aborted store; req_valid held during WAIT is not accepted until IDLE.
